// File: rtl/serial_frame_tx_if.sv
// ============================================================================
//  Module      : serial_frame_tx_if
//  Description : Byte handshake, bit strobe and serial-line bundle for
//                serial_frame_tx. The master drives the byte and strobe,
//                and the slave (the transmitter) drives the line and status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       lsb_first;
  logic       bit_en;
  logic       ser_out;
  logic       busy;
  logic       done;

  modport master (
    output tx_data, tx_valid, lsb_first, bit_en,
    input  tx_ready, ser_out, busy, done
  );

  modport slave (
    input  tx_data, tx_valid, lsb_first, bit_en,
    output tx_ready, ser_out, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ============================================================================
//  Module      : serial_frame_tx
//  Description : Frames one byte onto a serial line as
//                start(0), 8 data bits (MSB- or LSB-first), optional even
//                parity, and stop(1). The frame advances only on cycles
//                where bit_en is high.
//                Optional feature macro: SERIAL_FRAME_TX_PARITY_EN
//                (when defined, an even-parity bit follows the data bits).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_tx (
  input  wire logic          clk,
  input  wire logic          rst_n,
  serial_frame_tx_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_shreg;
  logic [2:0] r_cnt;
  logic       r_lsb;
  logic       r_ser;
  logic       r_done;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic       r_parity;
`endif

  logic [7:0] w_shifted;
  logic       w_next_bit;

  // Shift the register one place in the latched order and pick the bit that
  // becomes visible once the shift has happened.
  always_comb begin
    w_shifted  = r_lsb ? {1'b0, r_shreg[7:1]} : {r_shreg[6:0], 1'b0};
    w_next_bit = r_lsb ? r_shreg[1] : r_shreg[6];
  end

  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.ser_out  = r_ser;
  assign bus.done     = r_done;

  // Frame sequencer: state, shift register, bit counter and registered line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shreg  <= 8'd0;
      r_cnt    <= 3'd0;
      r_lsb    <= 1'b0;
      r_ser    <= 1'b1;
      r_done   <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ser <= 1'b1;
          // bit_en is deliberately not looked at here: the start bit is
          // always at least one full clk wide.
          if (bus.tx_valid) begin
            r_shreg  <= bus.tx_data;
            r_lsb    <= bus.lsb_first;
            r_cnt    <= 3'd0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_parity <= ^bus.tx_data;
`endif
            r_ser    <= 1'b0;
            r_state  <= S_START;
          end
        end

        S_START: begin
          if (bus.bit_en) begin
            r_ser   <= r_lsb ? r_shreg[0] : r_shreg[7];
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (bus.bit_en) begin
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
              r_ser   <= r_parity;
              r_state <= S_PARITY;
`else
              r_ser   <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_ser <= w_next_bit;
            end
          end
        end

`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PARITY: begin
          if (bus.bit_en) begin
            r_ser   <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (bus.bit_en) begin
            r_ser   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_ser   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// ============================================================================
//  Module      : tb_serial_frame_tx
//  Description : Directed self-checking bench for serial_frame_tx.
//                Honours SERIAL_FRAME_TX_PARITY_EN for expected frames.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_frame_tx_if bus ();

  serial_frame_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a frame from the data bits in transmit order (first bit at MSB)
  // and the hand-computed even parity bit. First line bit sits at seq[NB-1].
  function automatic logic [10:0] mk(input logic [7:0] bits_tx, input logic par);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    return {1'b0, bits_tx, par, 1'b1};
`else
    return {1'b0, 1'b0, bits_tx, 1'b1};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] d, input logic lsb);
    bus.tx_data   = d;
    bus.lsb_first = lsb;
    bus.tx_valid  = 1'b1;
    step();
  endtask

  // Walk the frame from the START cycle, one line bit per 'period' clks.
  task automatic run_bits(input string tag, input logic [10:0] seq, input int period, input bit chg);
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < period; j++) begin
        bus.bit_en = (j == period - 1);
        if (chg && i == 3 && j == 0) begin
          bus.tx_data   = ~bus.tx_data;
          bus.lsb_first = ~bus.lsb_first;
        end
        chk($sformatf("%s ser_out bit%0d clk%0d", tag, i, j), 32'(bus.ser_out), 32'(seq[NB-1-i]));
        chk($sformatf("%s busy bit%0d clk%0d", tag, i, j), 32'(bus.busy), 32'd1);
        chk($sformatf("%s done bit%0d clk%0d", tag, i, j), 32'(bus.done), 32'd0);
        step();
      end
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic lsb,
                       input logic [10:0] seq, input int period, input bit chg);
    bus.bit_en = (period == 1);
    accept(d, lsb);
    bus.tx_valid = 1'b0;
    run_bits(tag, seq, period, chg);
    chk({tag, " done pulse"}, 32'(bus.done), 32'd1);
    chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " idle ser_out"}, 32'(bus.ser_out), 32'd1);
    chk({tag, " idle tx_ready"}, 32'(bus.tx_ready), 32'd1);
    bus.bit_en = 1'b0;
    step();
    chk({tag, " done cleared"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;
    bus.lsb_first = 1'b0;
    bus.bit_en    = 1'b0;

    // Reset state.
    repeat (3) step();
    chk("rst ser_out", 32'(bus.ser_out), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst tx_ready", 32'(bus.tx_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Continuous bit_en frames.
    frame("A5msb", 8'hA5, 1'b0, mk(8'b1010_0101, 1'b0), 1, 1'b0);
    frame("A5lsb", 8'hA5, 1'b1, mk(8'b1010_0101, 1'b0), 1, 1'b0);
    frame("01lsb", 8'h01, 1'b1, mk(8'b1000_0000, 1'b1), 1, 1'b0);
    frame("07msb", 8'h07, 1'b0, mk(8'b0000_0111, 1'b1), 1, 1'b0);
    frame("03msb", 8'h03, 1'b0, mk(8'b0000_0011, 1'b0), 1, 1'b0);

    // bit_en every 4th clk, with tx_data/lsb_first disturbed mid-frame.
    frame("A5slow", 8'hA5, 1'b0, mk(8'b1010_0101, 1'b0), 4, 1'b1);

    // Idle with tx_valid low: bit_en toggling has no effect.
    for (int k = 0; k < 6; k++) begin
      bus.bit_en = k[0];
      step();
      chk($sformatf("idle ser_out %0d", k), 32'(bus.ser_out), 32'd1);
      chk($sformatf("idle busy %0d", k), 32'(bus.busy), 32'd0);
      chk($sformatf("idle done %0d", k), 32'(bus.done), 32'd0);
    end

    // Reset during the 4th data bit of A5 (MSB first: 1,0,1,0 -> line 0).
    bus.bit_en = 1'b1;
    accept(8'hA5, 1'b0);
    bus.tx_valid = 1'b0;
    repeat (4) step();
    chk("mid D3 ser_out", 32'(bus.ser_out), 32'd0);
    chk("mid D3 busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst ser_out", 32'(bus.ser_out), 32'd1);
    chk("mid rst busy", 32'(bus.busy), 32'd0);
    chk("mid rst tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("mid rst done", 32'(bus.done), 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("post rst ser_out %0d", k), 32'(bus.ser_out), 32'd1);
      chk($sformatf("post rst done %0d", k), 32'(bus.done), 32'd0);
      chk($sformatf("post rst busy %0d", k), 32'(bus.busy), 32'd0);
    end

    // Back-to-back frames with tx_valid held high: one IDLE cycle between.
    bus.bit_en = 1'b1;
    accept(8'h3C, 1'b0);
    bus.tx_data = 8'hC3;
    run_bits("b2b 3C", mk(8'b0011_1100, 1'b0), 1, 1'b0);
    chk("b2b gap done", 32'(bus.done), 32'd1);
    chk("b2b gap tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("b2b gap ser_out", 32'(bus.ser_out), 32'd1);
    step();
    bus.tx_valid = 1'b0;
    run_bits("b2b C3", mk(8'b1100_0011, 1'b0), 1, 1'b0);
    chk("b2b end done", 32'(bus.done), 32'd1);
    bus.bit_en = 1'b0;
    step();
    chk("b2b end done cleared", 32'(bus.done), 32'd0);
    chk("b2b end busy", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
